name_display_sequencer: RTL and testbench

Controller for the single seven-segment digit in the name-display design. Steps a character index 0..NUM_CHARS-1 at a programmable dwell rate, with pause and single-step controls. Arbitrates the digit between its own name sequence and an external override requester via a req/gnt handshake. Output `digit` feeds the existing `seg7` decoder; `blank` gates the segments at top level.

---
 rtl/name_display_sequencer_pkg.sv | 23 ++
 rtl/name_display_sequencer_if.sv | 22 ++
 rtl/name_display_sequencer_dwell_timer.sv | 29 ++
 rtl/name_display_sequencer.sv | 153 +++++++++++++++
 tb/tb_name_display_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/name_display_sequencer_pkg.sv
// Shared types and constants for the name-display digit sequencer.
package display_pkg;

  // Who currently owns the digit, or whether it is blanked between characters.
  typedef enum logic [1:0] {
    SHOW = 2'd0,
    GAP  = 2'd1,
    OVR  = 2'd2
  } state_e;

  localparam int unsigned CODE_W = 4;

  // Code loaded into the digit register when nothing meaningful is on display.
  localparam logic [CODE_W-1:0] BLANK_CODE = '0;

  // Bits needed for a counter whose largest value is max(a, b) - 1.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/name_display_sequencer_if.sv
// Override handshake between an external requester and the digit sequencer.
interface name_display_sequencer_if;

  logic                          ovr_req;
  logic [display_pkg::CODE_W-1:0] ovr_code;
  logic                          ovr_gnt;

  // Requester side.
  modport master (
    output ovr_req,
    output ovr_code,
    input  ovr_gnt
  );

  // Sequencer side.
  modport slave (
    input  ovr_req,
    input  ovr_code,
    output ovr_gnt
  );

endinterface

// File: rtl/name_display_sequencer_dwell_timer.sv
// Dwell/gap timer shared by the SHOW and GAP phases. Counts up to a
// caller-selected terminal value and holds there until cleared.
module dwell_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [Width-1:0] i_term,
  output logic             o_tc
);

  logic [Width-1:0] r_count;

  assign o_tc = (r_count == i_term);

  // Count while enabled; never step past the terminal value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + Width'(1);
    end
  end

endmodule

// File: rtl/name_display_sequencer.sv
// Seven-segment digit sequencer: steps through NUM_CHARS character codes at a
// programmable dwell rate, with pause/single-step, and yields the digit to an
// external override requester via a req/gnt handshake.
// Optional feature macro: BLANK_GAP_EN inserts a blank GAP_CYCLES interval
// after every advance; when undefined there is no GAP state and o_blank is 0.
module name_display_sequencer
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 10_000_000,
  parameter int unsigned NUM_CHARS    = 8,
  parameter int unsigned GAP_CYCLES   = 1_000_000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_run,
  input  logic                     i_step,
  name_display_sequencer_if.slave  io_ovr,
  output logic [CODE_W-1:0]        o_digit,
  output logic                     o_blank,
  output logic [3:0]               o_index,
  output logic                     o_wrap
);

  localparam int unsigned     CntW      = cnt_width(DWELL_CYCLES, GAP_CYCLES);
  localparam logic [CntW-1:0] DwellTerm = CntW'(DWELL_CYCLES - 1);
  localparam logic [3:0]      LastIdx   = 4'(NUM_CHARS - 1);

  state_e            r_state;
  state_e            r_resume;
  logic [3:0]        r_index;
  logic [CODE_W-1:0] r_digit;
  logic              r_blank;
  logic              r_gnt;
  logic              r_wrap;

  logic              w_tc;
  logic              w_cnt_en;
  logic              w_cnt_clr;
  logic              w_advance;
  logic              w_gap_done;
  logic [CntW-1:0]   w_term;
  logic [3:0]        w_next_index;

  assign w_next_index = (r_index == LastIdx) ? 4'd0 : r_index + 4'd1;

`ifdef BLANK_GAP_EN
  localparam logic [CntW-1:0] GapTerm = CntW'(GAP_CYCLES - 1);
  assign w_term = (r_state == GAP) ? GapTerm : DwellTerm;
`else
  assign w_term = DwellTerm;
`endif

  dwell_timer #(
    .Width (CntW)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_cnt_en),
    .i_clr  (w_cnt_clr),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  // Timer control and advance decision; a pending override freezes everything.
  always_comb begin
    w_advance  = 1'b0;
    w_gap_done = 1'b0;
    w_cnt_en   = 1'b0;
    w_cnt_clr  = 1'b0;
    unique case (r_state)
      SHOW: begin
        if (!io_ovr.ovr_req) begin
          // step and terminal count together still give one advance
          if (i_step || (i_run && w_tc)) begin
            w_advance = 1'b1;
            w_cnt_clr = 1'b1;
          end else if (i_run) begin
            w_cnt_en = 1'b1;
          end
        end
      end
`ifdef BLANK_GAP_EN
      GAP: begin
        // gap runs regardless of i_run
        if (!io_ovr.ovr_req) begin
          if (w_tc) begin
            w_gap_done = 1'b1;
            w_cnt_clr  = 1'b1;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Main FSM: owns index, resume state and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= SHOW;
      r_resume <= SHOW;
      r_index  <= 4'd0;
      r_digit  <= BLANK_CODE;
      r_blank  <= 1'b0;
      r_gnt    <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      unique case (r_state)
        OVR: begin
          if (io_ovr.ovr_req) begin
            r_digit <= io_ovr.ovr_code;
          end else begin
            r_state <= r_resume;
            r_gnt   <= 1'b0;
            r_digit <= r_index;
            r_blank <= (r_resume == GAP);
          end
        end
        default: begin
          // SHOW or GAP; override wins over advance and gap completion
          if (io_ovr.ovr_req) begin
            r_resume <= r_state;
            r_state  <= OVR;
            r_gnt    <= 1'b1;
            r_blank  <= 1'b0;
            r_digit  <= io_ovr.ovr_code;
          end else if (w_advance) begin
            r_index <= w_next_index;
            r_digit <= w_next_index;
            r_wrap  <= (r_index == LastIdx);
`ifdef BLANK_GAP_EN
            r_state <= GAP;
            r_blank <= 1'b1;
`endif
          end else if (w_gap_done) begin
            r_state <= SHOW;
            r_blank <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io_ovr.ovr_gnt = r_gnt;
  assign o_digit        = r_digit;
  assign o_blank        = r_blank;
  assign o_index        = r_index;
  assign o_wrap         = r_wrap;

endmodule

// File: tb/tb_name_display_sequencer.sv
// Self-checking bench for name_display_sequencer: directed scenarios plus a
// randomized run compared cycle-by-cycle against a behavioural model.
module tb_name_display_sequencer;

  localparam int Dwell = 4;
  localparam int Chars = 3;
  localparam int Gap   = 2;
`ifdef BLANK_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  localparam int PhShow = 0;
  localparam int PhGap  = 1;
  localparam int PhOvr  = 2;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       run  = 1'b0;
  logic       step = 1'b0;
  logic [3:0] digit;
  logic [3:0] index;
  logic       blank;
  logic       wrap;

  name_display_sequencer_if ovr_if ();

  name_display_sequencer #(
    .DWELL_CYCLES (Dwell),
    .NUM_CHARS    (Chars),
    .GAP_CYCLES   (Gap)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_run   (run),
    .i_step  (step),
    .io_ovr  (ovr_if),
    .o_digit (digit),
    .o_blank (blank),
    .o_index (index),
    .o_wrap  (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: which character is showing, how long it has been on
  // screen, and who owns the digit.
  int m_phase;
  int m_resume;
  int m_idx;
  int m_time;
  int m_digit;
  bit m_blank;
  bit m_gnt;
  bit m_wrap;

  function automatic void model_reset();
    m_phase  = PhShow;
    m_resume = PhShow;
    m_idx    = 0;
    m_time   = 0;
    m_digit  = 0;
    m_blank  = 1'b0;
    m_gnt    = 1'b0;
    m_wrap   = 1'b0;
  endfunction

  function automatic void model_step(bit run_v, bit step_v, bit req_v, logic [3:0] code_v);
    m_wrap = 1'b0;
    if (m_phase == PhOvr) begin
      if (req_v) begin
        m_digit = int'(code_v);
      end else begin
        m_phase = m_resume;
        m_gnt   = 1'b0;
        m_digit = m_idx;
        m_blank = (m_resume == PhGap);
      end
    end else if (req_v) begin
      m_resume = m_phase;
      m_phase  = PhOvr;
      m_gnt    = 1'b1;
      m_blank  = 1'b0;
      m_digit  = int'(code_v);
    end else if (m_phase == PhShow) begin
      if (step_v || (run_v && m_time == Dwell - 1)) begin
        m_idx   = (m_idx + 1) % Chars;
        m_wrap  = (m_idx == 0);
        m_time  = 0;
        m_digit = m_idx;
        if (GapEn) begin
          m_phase = PhGap;
          m_blank = 1'b1;
        end
      end else if (run_v) begin
        m_time++;
      end
    end else begin
      m_time++;
      if (m_time == Gap) begin
        m_time  = 0;
        m_phase = PhShow;
        m_blank = 1'b0;
      end
    end
  endfunction

  function automatic logic [10:0] obs_vec();
    return {ovr_if.ovr_gnt, digit, blank, index, wrap};
  endfunction

  function automatic logic [10:0] exp_vec();
    return {m_gnt, 4'(m_digit), m_blank, 4'(m_idx), m_wrap};
  endfunction

  // One clock: advance the model on the inputs the DUT will sample, then
  // settle just after the edge.
  task automatic tick();
    if (rst) model_reset();
    else model_step(run, step, ovr_if.ovr_req, ovr_if.ovr_code);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ovr_if.ovr_req = 1'b0;
    step = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ovr_if.ovr_req  = 1'b0;
    ovr_if.ovr_code = 4'h0;
    run  = 1'b1;
    rst  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs_vec() !== 11'b0) begin
      n_errors++;
      $display("FAIL reset_state: got %b want %b", obs_vec(), 11'b0);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_release: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_sequence();
    int seq [13];
    seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    run = 1'b1;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      if (k > 0) tick();
`ifndef BLANK_GAP_EN
      n_checks++;
      if (index !== 4'(seq[k]) || wrap !== (k == 12)) begin
        n_errors++;
        $display("FAIL seq_index cyc %0d: got idx %0d wrap %b want idx %0d wrap %b",
                 k, index, wrap, seq[k], (k == 12));
      end
`endif
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL seq_model cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_step();
    run = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    n_checks++;
    if (index !== 4'd1 || digit !== 4'd1) begin
      n_errors++;
      $display("FAIL step_advance: got idx %0d digit %0d want 1 1", index, digit);
    end
    ovr_if.ovr_req  = 1'b1;
    ovr_if.ovr_code = 4'h5;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    n_checks++;
    if (index !== 4'd1 || ovr_if.ovr_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL step_in_ovr: got idx %0d gnt %b want 1 1", index, ovr_if.ovr_gnt);
    end
    ovr_if.ovr_req = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ovr_if.ovr_gnt !== 1'b0 || index !== 4'd1) begin
      n_errors++;
      $display("FAIL step_not_queued: got gnt %b idx %0d want 0 1", ovr_if.ovr_gnt, index);
    end
  endtask

  task automatic test_override();
    run = 1'b1;
    do_reset();
    tick();
    tick();
    ovr_if.ovr_req  = 1'b1;
    ovr_if.ovr_code = 4'hA;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (ovr_if.ovr_gnt !== 1'b1 || digit !== 4'hA || index !== 4'd0) begin
        n_errors++;
        $display("FAIL ovr_grant cyc %0d: got gnt %b digit %h idx %0d want 1 a 0",
                 k, ovr_if.ovr_gnt, digit, index);
      end
    end
    ovr_if.ovr_req = 1'b0;
    tick();
    n_checks++;
    if (ovr_if.ovr_gnt !== 1'b0 || digit !== 4'd0 || index !== 4'd0) begin
      n_errors++;
      $display("FAIL ovr_release: got gnt %b digit %h idx %0d want 0 0 0",
               ovr_if.ovr_gnt, digit, index);
    end
    tick();
    n_checks++;
    if (index !== 4'd0) begin
      n_errors++;
      $display("FAIL ovr_frozen_cnt: got idx %0d want 0", index);
    end
    tick();
    n_checks++;
    if (index !== 4'd1 || digit !== 4'd1) begin
      n_errors++;
      $display("FAIL ovr_resume_adv: got idx %0d digit %0d want 1 1", index, digit);
    end
  endtask

  task automatic test_ovr_at_terminal();
    run = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    ovr_if.ovr_req  = 1'b1;
    ovr_if.ovr_code = 4'h7;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (index !== 4'd0 || ovr_if.ovr_gnt !== 1'b1) begin
        n_errors++;
        $display("FAIL tc_ovr_hold cyc %0d: got idx %0d gnt %b want 0 1",
                 k, index, ovr_if.ovr_gnt);
      end
    end
    ovr_if.ovr_req = 1'b0;
    tick();
    n_checks++;
    if (index !== 4'd0 || ovr_if.ovr_gnt !== 1'b0) begin
      n_errors++;
      $display("FAIL tc_release: got idx %0d gnt %b want 0 0", index, ovr_if.ovr_gnt);
    end
    tick();
    n_checks++;
    if (index !== 4'd1 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL tc_late_adv: got idx %0d wrap %b want 1 0", index, wrap);
    end
  endtask

`ifdef BLANK_GAP_EN
  task automatic test_gap();
    run = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (blank !== 1'b1 || digit !== 4'd1 || index !== 4'd1) begin
      n_errors++;
      $display("FAIL gap_enter: got blank %b digit %0d idx %0d want 1 1 1", blank, digit, index);
    end
    run = 1'b0;
    tick();
    n_checks++;
    if (blank !== 1'b1 || digit !== 4'd1) begin
      n_errors++;
      $display("FAIL gap_second: got blank %b digit %0d want 1 1", blank, digit);
    end
    tick();
    n_checks++;
    if (blank !== 1'b0 || digit !== 4'd1) begin
      n_errors++;
      $display("FAIL gap_end: got blank %b digit %0d want 0 1", blank, digit);
    end
  endtask
`endif

  task automatic test_reset_in_ovr();
    run = 1'b1;
    do_reset();
    tick();
    tick();
    ovr_if.ovr_req  = 1'b1;
    ovr_if.ovr_code = 4'hC;
    tick();
    tick();
    n_checks++;
    if (ovr_if.ovr_gnt !== 1'b1 || digit !== 4'hC) begin
      n_errors++;
      $display("FAIL rst_ovr_pre: got gnt %b digit %h want 1 c", ovr_if.ovr_gnt, digit);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs_vec() !== 11'b0) begin
      n_errors++;
      $display("FAIL rst_in_ovr: got %b want %b", obs_vec(), 11'b0);
    end
    rst = 1'b0;
    ovr_if.ovr_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    run = 1'b1;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 11) == 0) ovr_if.ovr_req = ~ovr_if.ovr_req;
      ovr_if.ovr_code = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 249) == 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL random cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
    rst  = 1'b0;
    step = 1'b0;
    ovr_if.ovr_req = 1'b0;
  endtask

  initial begin
    ovr_if.ovr_req  = 1'b0;
    ovr_if.ovr_code = 4'h0;
    model_reset();
    test_reset();
    test_sequence();
    test_step();
    test_override();
    test_ovr_at_terminal();
`ifdef BLANK_GAP_EN
    test_gap();
`endif
    test_reset_in_ovr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
